medoip_rx: RTL and testbench

MEDOIP_RX -- requirements
Module: medoip_rx

---
 rtl/medoip_rx.sv | 212 +++++++++++++++++++++
 tb/tb_medoip_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/medoip_rx.sv
// rtl/medoip_rx.sv - MII receiver extracting a UDP payload byte stream from matching Ethernet/IPv4 frames.
// Optional FCS verification is compiled in with `define RX_CRC_CHECK_EN.
module medoip_rx #(
  parameter int HDR_LEN     = 42,
  parameter int MAX_PAYLOAD = 1472
) (
  input  logic        i_Clk,
  input  logic        i_nRst,
  input  logic        i_PhyRxDv,
  input  logic [3:0]  i_PhyRxData,
  input  logic [47:0] i_MacDest,
  input  logic [31:0] i_IpDest,
  input  logic [15:0] i_PortDest,
  input  logic [15:0] i_ts_PacketLength,
  output logic [7:0]  o_ts_data,
  output logic        o_ts_valid,
  output logic        o_ts_sync,
  output logic        o_FrameDone,
  output logic        o_FrameErr,
  output logic [15:0] o_DropCnt
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, FCS, DROP, WAIT_IDLE} state_t;

  localparam logic [15:0] HDR_LAST = 16'(HDR_LEN - 1);
  localparam logic [16:0] MAX_LEN  = 17'(MAX_PAYLOAD);

  state_t      state, state_nxt;
  logic        dv_q, last5, phase;
  logic [3:0]  lo_nib;
  logic [15:0] byte_cnt, udp_len;
  logic        mac_m, bc_m, mac_m_nxt, bc_m_nxt;
  logic [7:0]  rx_byte, mac_byte, exp_byte;
  logic        strobe, check, hdr_ok, len_bad, crc_bad;
  logic        sfd, emit, done_set, err_set, drop_inc, cnt_clr, cnt_inc, hdr_upd;

  assign rx_byte = {i_PhyRxData, lo_nib};
  assign strobe  = i_PhyRxDv && phase;
  assign udp_len = i_ts_PacketLength + 16'd8;
  assign len_bad = (i_ts_PacketLength == 16'd0) || ({1'b0, i_ts_PacketLength} > MAX_LEN);

  // Destination MAC must match entirely as unicast or entirely as broadcast.
  always_comb begin
    mac_byte  = 8'h00;
    exp_byte  = 8'h00;
    check     = 1'b0;
    hdr_ok    = 1'b1;
    mac_m_nxt = mac_m;
    bc_m_nxt  = bc_m;
    case (byte_cnt)
      16'd0:   mac_byte = i_MacDest[47:40];
      16'd1:   mac_byte = i_MacDest[39:32];
      16'd2:   mac_byte = i_MacDest[31:24];
      16'd3:   mac_byte = i_MacDest[23:16];
      16'd4:   mac_byte = i_MacDest[15:8];
      16'd5:   mac_byte = i_MacDest[7:0];
      default: mac_byte = 8'h00;
    endcase
    if (byte_cnt < 16'd6) begin
      mac_m_nxt = mac_m && (rx_byte == mac_byte);
      bc_m_nxt  = bc_m && (rx_byte == 8'hFF);
      hdr_ok    = mac_m_nxt || bc_m_nxt;
    end
    case (byte_cnt)
      16'd12:  begin check = 1'b1; exp_byte = 8'h08; end
      16'd13:  begin check = 1'b1; exp_byte = 8'h00; end
      16'd14:  begin check = 1'b1; exp_byte = 8'h45; end
      16'd23:  begin check = 1'b1; exp_byte = 8'h11; end
      16'd30:  begin check = 1'b1; exp_byte = i_IpDest[31:24]; end
      16'd31:  begin check = 1'b1; exp_byte = i_IpDest[23:16]; end
      16'd32:  begin check = 1'b1; exp_byte = i_IpDest[15:8]; end
      16'd33:  begin check = 1'b1; exp_byte = i_IpDest[7:0]; end
      16'd36:  begin check = 1'b1; exp_byte = i_PortDest[15:8]; end
      16'd37:  begin check = 1'b1; exp_byte = i_PortDest[7:0]; end
      16'd38:  begin check = 1'b1; exp_byte = udp_len[15:8]; end
      16'd39:  begin check = 1'b1; exp_byte = udp_len[7:0]; end
      default: begin check = 1'b0; exp_byte = 8'h00; end
    endcase
    if (check && (rx_byte != exp_byte)) hdr_ok = 1'b0;
    if ((byte_cnt == 16'd0) && len_bad) hdr_ok = 1'b0;
  end

`ifdef RX_CRC_CHECK_EN
  logic [31:0] crc, crc_nxt;

  always_comb begin
    crc_nxt = crc ^ {24'd0, rx_byte};
    for (int i = 0; i < 8; i++)
      crc_nxt = crc_nxt[0] ? ((crc_nxt >> 1) ^ 32'hEDB88320) : (crc_nxt >> 1);
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) crc <= 32'hFFFFFFFF;
    else if (sfd) crc <= 32'hFFFFFFFF;
    else if (strobe && ((state == HEADER) || (state == PAYLOAD) || (state == FCS))) crc <= crc_nxt;
  end

  // Register is LSB-first, so the 0xC704DD7B residue shows up bit-reversed.
  assign crc_bad = (crc_nxt != 32'hDEBB20E3);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sfd       = 1'b0;
    emit      = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    drop_inc  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    hdr_upd   = 1'b0;
    case (state)
      IDLE: if (i_PhyRxDv && !dv_q) state_nxt = PREAMBLE;
      PREAMBLE: begin
        if (!i_PhyRxDv) state_nxt = IDLE;
        else if ((i_PhyRxData == 4'hD) && last5) begin
          state_nxt = HEADER;
          sfd       = 1'b1;
        end else if (i_PhyRxData != 4'h5) state_nxt = DROP;
      end
      HEADER: begin
        if (!i_PhyRxDv) state_nxt = IDLE;
        else if (strobe) begin
          hdr_upd = 1'b1;
          if (!hdr_ok) begin
            state_nxt = DROP;
            drop_inc  = 1'b1;
          end else if (byte_cnt == HDR_LAST) begin
            state_nxt = PAYLOAD;
            cnt_clr   = 1'b1;
          end else cnt_inc = 1'b1;
        end
      end
      PAYLOAD: begin
        if (!i_PhyRxDv) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
          err_set   = 1'b1;
        end else if (strobe) begin
          emit = 1'b1;
          if (byte_cnt == i_ts_PacketLength - 16'd1) begin
            state_nxt = FCS;
            cnt_clr   = 1'b1;
          end else cnt_inc = 1'b1;
        end
      end
      FCS: begin
        if (!i_PhyRxDv) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
          err_set   = 1'b1;
        end else if (strobe) begin
          if (byte_cnt == 16'd3) begin
            state_nxt = WAIT_IDLE;
            done_set  = 1'b1;
            err_set   = crc_bad;
          end else cnt_inc = 1'b1;
        end
      end
      DROP, WAIT_IDLE: if (!i_PhyRxDv) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // dv_q resets high so a frame already in flight at reset release is ignored.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      dv_q        <= 1'b1;
      last5       <= 1'b0;
      phase       <= 1'b0;
      lo_nib      <= 4'h0;
      byte_cnt    <= 16'd0;
      mac_m       <= 1'b0;
      bc_m        <= 1'b0;
      o_ts_data   <= 8'h00;
      o_ts_valid  <= 1'b0;
      o_ts_sync   <= 1'b0;
      o_FrameDone <= 1'b0;
      o_FrameErr  <= 1'b0;
      o_DropCnt   <= 16'd0;
    end else begin
      dv_q  <= i_PhyRxDv;
      last5 <= i_PhyRxDv && (i_PhyRxData == 4'h5);
      if (sfd) begin
        phase <= 1'b0;
        mac_m <= 1'b1;
        bc_m  <= 1'b1;
      end else if (i_PhyRxDv) begin
        phase <= ~phase;
        if (!phase) lo_nib <= i_PhyRxData;
      end
      if (sfd || cnt_clr) byte_cnt <= 16'd0;
      else if (cnt_inc)   byte_cnt <= byte_cnt + 16'd1;
      if (hdr_upd) begin
        mac_m <= mac_m_nxt;
        bc_m  <= bc_m_nxt;
      end
      o_ts_valid  <= emit;
      o_ts_sync   <= emit && (byte_cnt == 16'd0);
      if (emit) o_ts_data <= rx_byte;
      o_FrameDone <= done_set;
      if (done_set) o_FrameErr <= err_set;
      if (drop_inc && (o_DropCnt != 16'hFFFF)) o_DropCnt <= o_DropCnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_medoip_rx.sv
// tb/tb_medoip_rx.sv - directed and randomized frame bench for medoip_rx with a frame-level reference model.
module tb_medoip_rx;
  logic        clk = 1'b0;
  logic        rst_n, dv;
  logic [3:0]  rxd;
  logic [47:0] mac;
  logic [31:0] ip;
  logic [15:0] port, plen;
  logic [7:0]  ts_data;
  logic        ts_valid, ts_sync, frame_done, frame_err;
  logic [15:0] drop_cnt;

`ifdef RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif
  localparam int HDR = 42;

  always #5 clk = ~clk;

  medoip_rx dut (
    .i_Clk(clk), .i_nRst(rst_n), .i_PhyRxDv(dv), .i_PhyRxData(rxd),
    .i_MacDest(mac), .i_IpDest(ip), .i_PortDest(port), .i_ts_PacketLength(plen),
    .o_ts_data(ts_data), .o_ts_valid(ts_valid), .o_ts_sync(ts_sync),
    .o_FrameDone(frame_done), .o_FrameErr(frame_err), .o_DropCnt(drop_cnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;
  byte unsigned got_data[$];
  bit got_sync[$];
  bit got_err[$];

  always @(negedge clk) begin
    if (ts_valid) begin
      got_data.push_back(ts_data);
      got_sync.push_back(ts_sync);
    end
    if (frame_done) got_err.push_back(frame_err);
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] crc32(input byte unsigned q[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c ^= {24'd0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // kind: 0 good, 1 MAC, 2 ethertype, 3 version, 4 protocol, 5 IP+1, 6 port, 7 UDP length, 8 broadcast, 9 bad FCS
  task automatic build(input int kind, input byte unsigned pl[$], output byte unsigned f[$]);
    logic [47:0] dst;
    logic [31:0] dip, fcs;
    logic [15:0] ulen, tlen, dport;
    f = {};
    dst   = (kind == 8) ? 48'hFFFF_FFFF_FFFF : ((kind == 1) ? (mac ^ 48'h0000_0100_0000) : mac);
    dip   = (kind == 5) ? ip + 32'd1 : ip;
    dport = (kind == 6) ? port ^ 16'h0001 : port;
    ulen  = 16'(pl.size()) + ((kind == 7) ? 16'd9 : 16'd8);
    tlen  = 16'(pl.size()) + 16'd28;
    for (int i = 0; i < 6; i++) f.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(8'($urandom));
    f.push_back((kind == 2) ? 8'h86 : 8'h08); f.push_back(8'h00);
    f.push_back((kind == 3) ? 8'h46 : 8'h45); f.push_back(8'h00);
    f.push_back(tlen[15:8]); f.push_back(tlen[7:0]);
    for (int i = 0; i < 4; i++) f.push_back(8'($urandom));
    f.push_back(8'h40); f.push_back((kind == 4) ? 8'h06 : 8'h11);
    for (int i = 0; i < 6; i++) f.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) f.push_back(dip[31-8*i -: 8]);
    for (int i = 0; i < 2; i++) f.push_back(8'($urandom));
    f.push_back(dport[15:8]); f.push_back(dport[7:0]);
    f.push_back(ulen[15:8]); f.push_back(ulen[7:0]);
    for (int i = 0; i < 2; i++) f.push_back(8'($urandom));
    foreach (pl[i]) f.push_back(pl[i]);
    fcs = ~crc32(f);
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
    if (kind == 9) f[f.size()-2] = f[f.size()-2] ^ 8'h10;
  endtask

  task automatic nib(input logic [3:0] n);
    dv = 1'b1; rxd = n;
    @(posedge clk); #1;
  endtask

  task automatic send(input byte unsigned f[$], input int trunc_at, input bit odd, input int rst_at, input int gap);
    logic [7:0] b;
    for (int i = 0; i < 15; i++) nib(4'h5);
    nib(4'hD);
    for (int i = 0; i < f.size(); i++) begin
      if (i == trunc_at) break;
      if (i == rst_at) begin
        rst_n = 1'b0; #1;
        chk("reset_mid_outputs", {4'd0, ts_data, ts_valid, ts_sync, frame_done, frame_err, drop_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        got_data.delete(); got_sync.delete(); got_err.delete();
        exp_drop = 0;
      end
      b = f[i];
      nib(b[3:0]);
      nib(b[7:4]);
    end
    if (odd) nib(4'hA);
    dv = 1'b0; rxd = 4'h0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic score(input string tag, input int kind, input int plen_in, input byte unsigned pl[$], input int trunc);
    bit accepted;
    int n_exp, bad, nsync;
    accepted = (plen_in >= 1) && (plen_in <= 1472) && (kind == 0 || kind == 8 || kind == 9);
    n_exp = !accepted ? 0 : ((trunc >= 0) ? trunc : pl.size());
    if (!accepted && exp_drop < 65535) exp_drop++;
    chk({tag, ".strobes"}, got_data.size(), n_exp);
    bad = 0; nsync = 0;
    foreach (got_data[i]) if (i < n_exp && got_data[i] != pl[i]) bad++;
    foreach (got_sync[i]) if (got_sync[i]) nsync++;
    chk({tag, ".data_mismatches"}, bad, 0);
    if (n_exp > 0) begin
      chk({tag, ".sync_count"}, nsync, 1);
      chk({tag, ".sync_first"}, (got_sync.size() > 0) ? got_sync[0] : 1'b0, 1);
    end
    chk({tag, ".done_count"}, got_err.size(), accepted ? 1 : 0);
    if (accepted && got_err.size() > 0)
      chk({tag, ".frame_err"}, got_err[0], (trunc >= 0) ? 1 : ((kind == 9) ? CRC_ON : 1'b0));
    chk({tag, ".drop_cnt"}, drop_cnt, exp_drop);
    got_data.delete(); got_sync.delete(); got_err.delete();
  endtask

  task automatic frame(input string tag, input int kind, input int len, input int plen_in, input bit ts_pat,
                       input int trunc, input bit odd, input int extra, input int gap);
    byte unsigned pl[$];
    byte unsigned f[$];
    for (int i = 0; i < len; i++) pl.push_back(ts_pat ? ((i == 0) ? 8'h47 : 8'h00) : 8'($urandom));
    plen = 16'(plen_in);
    build(kind, pl, f);
    repeat (extra) f.push_back(8'($urandom));
    send(f, (trunc >= 0) ? HDR + trunc : -1, odd, -1, gap);
    score(tag, kind, plen_in, pl, trunc);
  endtask

  initial begin
    byte unsigned pl[$];
    byte unsigned f[$];
    rst_n = 1'b0; dv = 1'b0; rxd = 4'h0;
    mac  = {16'h0250, 32'($urandom)};
    ip   = {8'd10, 24'($urandom)};
    port = 16'($urandom_range(1024, 60000));
    plen = 16'd188;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {4'd0, ts_data, ts_valid, ts_sync, frame_done, frame_err, drop_cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    frame("ts188_good", 0, 188, 188, 1'b1, -1, 1'b0, 0, 4);
    frame("ip_mismatch", 5, 188, 188, 1'b1, -1, 1'b0, 0, 4);
    frame("fcs_flip", 9, 188, 188, 1'b1, -1, 1'b0, 0, 4);
    frame("trunc100", 0, 188, 188, 1'b1, 100, 1'b1, 0, 4);
    frame("after_trunc", 0, 188, 188, 1'b1, -1, 1'b0, 0, 4);
    frame("len_zero", 0, 10, 0, 1'b0, -1, 1'b0, 0, 4);
    frame("len_too_big", 0, 10, 1473, 1'b0, -1, 1'b0, 0, 4);
    frame("len_one", 0, 1, 1, 1'b0, -1, 1'b0, 0, 4);
    frame("trailing_bytes", 0, 20, 20, 1'b0, -1, 1'b0, 5, 4);
    frame("bcast_a", 8, 30, 30, 1'b0, -1, 1'b0, 0, 1);
    frame("bcast_b", 8, 30, 30, 1'b0, -1, 1'b0, 0, 4);

    for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
    pl.delete();
    for (int i = 0; i < 120; i++) pl.push_back(8'($urandom));
    plen = 16'd120;
    build(8, pl, f);
    send(f, -1, 1'b0, HDR + 50, 4);
    chk("post_reset_strobes", got_data.size(), 0);
    chk("post_reset_done", got_err.size(), 0);
    chk("post_reset_drop_cnt", drop_cnt, 0);
    frame("recover", 0, 188, 188, 1'b1, -1, 1'b0, 0, 4);

    for (int r = 0; r < 12; r++) begin
      int kind, len;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 48);
      frame($sformatf("rand%0d_k%0d", r, kind), kind, len, len, 1'b0, -1, 1'b0, $urandom_range(0, 3), $urandom_range(1, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
